uart_rx_framed: RTL and testbench
=================================

Name: uart_rx_framed

Overview:
Parametrised successor to the single-config UART receiver. Adds configurable data width, optional parity, multi-stop-bit checking, 3-sample majority filtering, and a valid/ready output with parity, framing and overrun reporting. Sits between an asynchronous serial pin and a streaming consumer in the protocol library.

Parameters:
p_CLKS_PER_BIT, 16, clock cycles per bit slot; legal range is 4 or more.
p_DATA_BITS, 8, data bits per frame, LSB first; range 1..16.
p_PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
p_STOP_BITS, 1, stop bits checked per frame; range 1..4.
p_SYNC_STAGES, 2, flops in the i_rx synchroniser; 2 or more.

Ports:
i_clk  in  1  single system clock; all logic on the rising edge.
i_reset  in  1  synchronous, active-high reset.
i_rx  in  1  asynchronous serial line; idles high.
o_data  out  p_DATA_BITS  received word; valid while o_valid=1.
o_valid  out  1  word available.
i_ready  in  1  consumer accepts the word when o_valid & i_ready.
o_parity_err  out  1  parity mismatch for the held word; 0 when p_PARITY=0.
o_frame_err  out  1  one or more stop bits sampled low for the held word.
o_overrun  out  1  at least one later frame was dropped while this word was held.
o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: one clock with i_reset=1 forces state=IDLE and clears all outputs to 0. Synchroniser flops are set to 1. Reset mid-frame abandons that frame.
- Sampling point: mid = p_CLKS_PER_BIT/2 (integer division). Each bit slot takes samples of the synchronised line at slot cycles mid-1, mid and mid+1. The bit value is the majority of the 3 samples, decided at mid+1. The slot counter wraps at p_CLKS_PER_BIT-1.
- States and transitions:
  - IDLE: a high-to-low transition on the synchronised line moves to START with slot counter = 0.
  - START: if the majority is 0, go to DATA. If the majority is 1, this is a glitch: return to IDLE and produce no output.
  - DATA: shift bits in LSB first. After p_DATA_BITS bits, go to PARITY if p_PARITY != 0, otherwise go to STOP.
  - PARITY: compare the received bit with the computed odd/even parity. Store the error flag. Go to STOP.
  - STOP: run p_STOP_BITS slots. If any stop bit's majority is 0, set the frame-error flag. At the decision point of the last stop bit, commit the frame. Then go to IDLE, or to WAIT_IDLE if the last stop bit was 0.
  - WAIT_IDLE: hold until the synchronised line is 1, then go to IDLE. This prevents a break condition from being seen as repeated starts.
- Commit: o_data and the error flags load, and o_valid rises, on the clock after the final stop decision. Every committed frame is delivered, including frames with errors.
- Handshake: o_valid and all output fields hold stable until the cycle where o_valid & i_ready. After that cycle, o_valid drops unless a new commit occurs in the same cycle.
- Commit with a word already held (o_valid=1 and i_ready=0): the new frame is dropped, the held word is unchanged, and o_overrun is set to 1.
- Commit in the same cycle as a handshake: the new word loads, o_valid stays 1, and o_overrun=0. There is no overrun in this case.
- o_overrun clears when the word it accompanies is accepted.
- Latency from an i_rx edge to the internal line is p_SYNC_STAGES cycles. The receiver is back in IDLE at the mid-point of the last stop bit, so it tolerates roughly half a bit of baud mismatch per frame.
- Counters are sized with $clog2 of their range. There is no arithmetic overflow: every counter wraps at its terminal count.

Test Plan:
- Config 16/8/none/1. Send 0xA5 as 8N1 with i_ready=1. Expect o_data=0xA5 and o_valid high for 1 cycle, with o_parity_err=0, o_frame_err=0 and o_overrun=0.
- p_PARITY=2. Send 0x3C with parity bit 1 (correct even parity is 0). Expect o_data=0x3C and o_parity_err=1. Then send 0x3C with parity bit 0 and expect o_parity_err=0.
- Send 0x55 with the stop bit low and keep the line low for 40 cycles. Expect o_frame_err=1, o_busy=1 until the line returns high, and no second frame. A following 0x12 frame is received cleanly.
- Glitch tests:
  - A 3-cycle low pulse on an idle line produces no o_valid and returns to IDLE after the start slot.
  - A 1-cycle inverted glitch at mid inside data bit 3 of 0xF0 still yields o_data=0xF0.
- Overrun: hold i_ready=0 and send 0x11 then 0x22. Expect o_data=0x11 and o_overrun=1 after the second frame. Raise i_ready for 1 cycle: o_valid drops and o_overrun clears. Then send 0x33 and expect it with o_overrun=0.
- Pulse i_reset during data bit 4 of a frame. All outputs are 0 the next cycle and no frame is output. Send 0x81 afterwards and it is received correctly.
- Repeat the first test with p_DATA_BITS=5, p_STOP_BITS=2 and p_CLKS_PER_BIT=4, sending 0x1B. Expect o_data=0x1B.

Source files
------------

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: configurable UART receiver with a valid/ready output.
//
// Each frame has a start bit, p_DATA_BITS data bits sent LSB first, an
// optional parity bit and p_STOP_BITS stop bits. Every bit slot is sampled
// three times around its middle, and a majority vote of those samples
// decides the bit value. Every completed frame is committed to the output,
// including frames with parity or framing errors. If a word is still held
// when a new frame completes, the new frame is dropped and the overrun flag
// is raised on the held word.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      synchronous active-high reset
//   i_rx         asynchronous serial input, idles high
//   o_data       received word, meaningful while o_valid=1
//   o_valid      word available
//   i_ready      consumer takes the word when o_valid & i_ready
//   o_parity_err parity mismatch on the held word (0 when p_PARITY=0)
//   o_frame_err  at least one stop bit of the held word sampled low
//   o_overrun    a later frame was dropped while this word was held
//   o_busy       receiver is in any state other than IDLE
module uart_rx_framed #(
  parameter int p_CLKS_PER_BIT = 16,
  parameter int p_DATA_BITS    = 8,
  parameter int p_PARITY       = 0,
  parameter int p_STOP_BITS    = 1,
  parameter int p_SYNC_STAGES  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_rx,
  output logic [p_DATA_BITS-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_parity_err,
  output logic                   o_frame_err,
  output logic                   o_overrun,
  output logic                   o_busy
);

  localparam int CNT_W    = $clog2(p_CLKS_PER_BIT);
  localparam int MID      = p_CLKS_PER_BIT / 2;
  localparam int BITS_MAX = (p_DATA_BITS > p_STOP_BITS) ? p_DATA_BITS : p_STOP_BITS;
  localparam int BIT_W    = (BITS_MAX > 1) ? $clog2(BITS_MAX) : 1;

  localparam logic [CNT_W-1:0] SAMP_A    = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] SAMP_B    = CNT_W'(MID);
  localparam logic [CNT_W-1:0] SAMP_C    = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(p_CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(p_DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(p_STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t state;
  state_t state_next;

  logic [p_SYNC_STAGES-1:0] sync;
  logic                     line;
  logic                     line_next;
  logic [CNT_W-1:0]         cnt;
  logic [BIT_W-1:0]         bitcnt;
  logic                     samp_a;
  logic                     samp_b;
  logic [p_DATA_BITS-1:0]   shreg;
  logic [p_DATA_BITS-1:0]   msb_bit;
  logic                     perr;
  logic                     ferr;
  logic                     decide;
  logic                     bit_val;
  logic                     commit;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Flags a mismatch between the received parity bit and the data word.
  function automatic logic parity_err(input logic [p_DATA_BITS-1:0] d, input logic b);
    logic ones_odd;
    ones_odd = (^d) ^ b;
    return (p_PARITY == 1) ? ~ones_odd : ones_odd;
  endfunction

  // The edge detector looks one stage ahead in the synchroniser. The START
  // state then begins on the first cycle that the line reads low, so slot
  // counter 0 lines up with the start of the bit on the synchronised line.
  assign line      = sync[p_SYNC_STAGES-1];
  assign line_next = sync[p_SYNC_STAGES-2];

  assign decide  = (cnt == SAMP_C) &&
                   (state == START || state == DATA || state == PARITY || state == STOP);
  assign bit_val = maj3(samp_a, samp_b, line);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync  <= '1;
      state <= IDLE;
    end else begin
      sync  <= {sync[p_SYNC_STAGES-2:0], i_rx};
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    commit     = 1'b0;
    o_busy     = (state != IDLE);
    case (state)
      IDLE: begin
        if (line && !line_next) state_next = START;
      end
      START: begin
        if (decide) state_next = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (decide && bitcnt == DATA_LAST) state_next = (p_PARITY != 0) ? PARITY : STOP;
      end
      PARITY: begin
        if (decide) state_next = STOP;
      end
      STOP: begin
        if (decide && bitcnt == STOP_LAST) begin
          commit = 1'b1;
          // A low final stop bit may be a break; wait for the line to
          // return high so the break is not taken as another start.
          state_next = bit_val ? IDLE : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (line) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt    <= '0;
      bitcnt <= '0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      if (state == IDLE || state == WAIT_IDLE) cnt <= '0;
      else if (cnt == CNT_LAST) cnt <= '0;
      else cnt <= cnt + 1'b1;

      if (state == IDLE) begin
        bitcnt <= '0;
        perr   <= 1'b0;
        ferr   <= 1'b0;
      end else if (decide) begin
        case (state)
          DATA:    bitcnt <= (bitcnt == DATA_LAST) ? '0 : bitcnt + 1'b1;
          PARITY:  perr <= parity_err(shreg, bit_val);
          STOP: begin
            bitcnt <= (bitcnt == STOP_LAST) ? '0 : bitcnt + 1'b1;
            if (!bit_val) ferr <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    msb_bit                = '0;
    msb_bit[p_DATA_BITS-1] = bit_val;
  end

  always_ff @(posedge i_clk) begin
    if (cnt == SAMP_A) samp_a <= line;
    if (cnt == SAMP_B) samp_b <= line;
    if (decide && state == DATA) shreg <= (shreg >> 1) | msb_bit;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_data       <= '0;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else if (commit) begin
      if (!o_valid || i_ready) begin
        o_data       <= shreg;
        o_parity_err <= perr;
        o_frame_err  <= ferr | ~bit_val;
        o_valid      <= 1'b1;
        o_overrun    <= 1'b0;
      end else begin
        o_overrun    <= 1'b1;
      end
    end else if (o_valid && i_ready) begin
      o_valid   <= 1'b0;
      o_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: three receiver instances with different
// configurations, each fed by its own serial line. Expected words are queued
// when a frame is sent and a monitor compares them on every handshake.
module tb_uart_rx_framed;

  localparam int CPB   [3] = '{16, 16, 4};
  localparam int DBITS [3] = '{8, 8, 5};
  localparam int PAR   [3] = '{0, 2, 0};
  localparam int SBITS [3] = '{1, 1, 2};
  localparam int SYNC  [3] = '{2, 3, 2};

  typedef struct packed {
    logic [15:0] data;
    logic        perr;
    logic        ferr;
    logic        ovr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx    [3];
  logic        ready [3];
  logic        vld   [3];
  logic        pe    [3];
  logic        fe    [3];
  logic        ov    [3];
  logic        busy  [3];
  logic [15:0] dout  [3];
  logic [7:0]  d0;
  logic [7:0]  d1;
  logic [4:0]  d2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign dout[0] = {8'h00, d0};
  assign dout[1] = {8'h00, d1};
  assign dout[2] = {11'h000, d2};

  uart_rx_framed #(.p_CLKS_PER_BIT(CPB[0]), .p_DATA_BITS(DBITS[0]), .p_PARITY(PAR[0]),
                   .p_STOP_BITS(SBITS[0]), .p_SYNC_STAGES(SYNC[0])) dut0 (
    .i_clk(clk), .i_reset(rst), .i_rx(rx[0]), .o_data(d0), .o_valid(vld[0]),
    .i_ready(ready[0]), .o_parity_err(pe[0]), .o_frame_err(fe[0]),
    .o_overrun(ov[0]), .o_busy(busy[0]));

  uart_rx_framed #(.p_CLKS_PER_BIT(CPB[1]), .p_DATA_BITS(DBITS[1]), .p_PARITY(PAR[1]),
                   .p_STOP_BITS(SBITS[1]), .p_SYNC_STAGES(SYNC[1])) dut1 (
    .i_clk(clk), .i_reset(rst), .i_rx(rx[1]), .o_data(d1), .o_valid(vld[1]),
    .i_ready(ready[1]), .o_parity_err(pe[1]), .o_frame_err(fe[1]),
    .o_overrun(ov[1]), .o_busy(busy[1]));

  uart_rx_framed #(.p_CLKS_PER_BIT(CPB[2]), .p_DATA_BITS(DBITS[2]), .p_PARITY(PAR[2]),
                   .p_STOP_BITS(SBITS[2]), .p_SYNC_STAGES(SYNC[2])) dut2 (
    .i_clk(clk), .i_reset(rst), .i_rx(rx[2]), .o_data(d2), .o_valid(vld[2]),
    .i_ready(ready[2]), .o_parity_err(pe[2]), .o_frame_err(fe[2]),
    .o_overrun(ov[2]), .o_busy(busy[2]));

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int d, input exp_t e);
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic qpop(input int d, output exp_t e);
    case (d)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  // The held word keeps its contents; only its overrun flag changes.
  task automatic qmark_ovr(input int d);
    exp_t e;
    case (d)
      0:       begin e = q0.pop_back(); e.ovr = 1'b1; q0.push_back(e); end
      1:       begin e = q1.pop_back(); e.ovr = 1'b1; q1.push_back(e); end
      default: begin e = q2.pop_back(); e.ovr = 1'b1; q2.push_back(e); end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted word must match the oldest expected word.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst && vld[d] && ready[d]) begin : pop_blk
        exp_t e;
        if (qsize(d) == 0) begin
          checks++;
          errors++;
          $display("FAIL dut%0d unexpected word: got data 0x%0h, expected no word", d, dout[d]);
        end else begin
          qpop(d, e);
          chk($sformatf("dut%0d data", d), dout[d], e.data);
          chk($sformatf("dut%0d parity_err", d), 16'(pe[d]), 16'(e.perr));
          chk($sformatf("dut%0d frame_err", d), 16'(fe[d]), 16'(e.ferr));
          chk($sformatf("dut%0d overrun", d), 16'(ov[d]), 16'(e.ovr));
        end
      end
    end
  end

  // Drives one frame on line d. stop_low marks stop bits driven low,
  // glitch_bit (>=0) inverts one cycle in the middle of that data bit,
  // rst_bit (>=0) pulses reset in the middle of that data bit and abandons
  // the frame. keep_low leaves the line low after the frame.
  task automatic send(input int d, input logic [15:0] data, input bit bad_par,
                      input logic [3:0] stop_low, input int glitch_bit,
                      input int rst_bit, input bit keep_low);
    int          c;
    int          nb;
    int          ns;
    int          n;
    int          ones;
    logic [31:0] sl;
    logic [15:0] mask;
    exp_t        e;
    c    = CPB[d];
    nb   = DBITS[d];
    ns   = SBITS[d];
    mask = 16'((32'd1 << nb) - 1);
    data = data & mask;
    sl    = '1;
    sl[0] = 1'b0;
    n     = 1;
    for (int i = 0; i < nb; i++) begin
      sl[n] = data[i];
      n++;
    end
    if (PAR[d] != 0) begin
      ones  = $countones(data);
      sl[n] = (PAR[d] == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
      if (bad_par) sl[n] = ~sl[n];
      n++;
    end
    for (int i = 0; i < ns; i++) begin
      sl[n] = ~stop_low[i];
      n++;
    end
    if (rst_bit < 0) begin
      e.data = data;
      e.perr = (PAR[d] != 0) && bad_par;
      e.ferr = |(stop_low & 4'((1 << ns) - 1));
      e.ovr  = 1'b0;
      if (!ready[d] && qsize(d) > 0) qmark_ovr(d);
      else qpush(d, e);
    end
    for (int s = 0; s < n; s++) begin
      for (int k = 0; k < c; k++) begin
        tick();
        rx[d] = sl[s];
        if (glitch_bit >= 0 && s == glitch_bit + 1 && k == c / 2) rx[d] = ~sl[s];
        if (rst_bit >= 0 && s == rst_bit + 1 && k == c / 2) begin
          rst = 1'b1;
          tick();
          rst   = 1'b0;
          rx[d] = 1'b1;
          q0.delete();
          q1.delete();
          q2.delete();
          @(negedge clk);
          chk($sformatf("dut%0d reset valid", d), 16'(vld[d]), 16'h0);
          chk($sformatf("dut%0d reset data", d), dout[d], 16'h0);
          chk($sformatf("dut%0d reset parity_err", d), 16'(pe[d]), 16'h0);
          chk($sformatf("dut%0d reset frame_err", d), 16'(fe[d]), 16'h0);
          chk($sformatf("dut%0d reset overrun", d), 16'(ov[d]), 16'h0);
          chk($sformatf("dut%0d reset busy", d), 16'(busy[d]), 16'h0);
          repeat (c + 6) tick();
          return;
        end
      end
    end
    if (!keep_low) begin
      tick();
      rx[d] = 1'b1;
      repeat (c + 6) tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      rx[d]    = 1'b1;
      ready[d] = 1'b1;
    end
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d post-reset valid", d), 16'(vld[d]), 16'h0);
      chk($sformatf("dut%0d post-reset busy", d), 16'(busy[d]), 16'h0);
    end
    repeat (4) tick();

    // 8N1 word accepted straight away
    send(0, 16'hA5, 1'b0, 4'b0, -1, -1, 1'b0);
    chk("dut0 valid after accept", 16'(vld[0]), 16'h0);

    // even parity: wrong bit then right bit
    send(1, 16'h3C, 1'b1, 4'b0, -1, -1, 1'b0);
    send(1, 16'h3C, 1'b0, 4'b0, -1, -1, 1'b0);

    // break: stop bit low and the line held low
    send(0, 16'h55, 1'b0, 4'b0001, -1, -1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i % 10 == 9) chk("dut0 busy during break", 16'(busy[0]), 16'h1);
    end
    rx[0] = 1'b1;
    repeat (8) tick();
    chk("dut0 busy after break", 16'(busy[0]), 16'h0);
    send(0, 16'h12, 1'b0, 4'b0, -1, -1, 1'b0);

    // short low pulse on an idle line
    rx[0] = 1'b0;
    repeat (3) tick();
    rx[0] = 1'b1;
    repeat (3) tick();
    chk("dut0 busy in start slot", 16'(busy[0]), 16'h1);
    repeat (20) tick();
    chk("dut0 busy after glitch", 16'(busy[0]), 16'h0);
    chk("dut0 valid after glitch", 16'(vld[0]), 16'h0);

    // one-cycle glitch inside data bit 3
    send(0, 16'hF0, 1'b0, 4'b0, 3, -1, 1'b0);

    // overrun with the consumer stalled
    ready[0] = 1'b0;
    send(0, 16'h11, 1'b0, 4'b0, -1, -1, 1'b0);
    send(0, 16'h22, 1'b0, 4'b0, -1, -1, 1'b0);
    chk("dut0 held valid", 16'(vld[0]), 16'h1);
    chk("dut0 held data", dout[0], 16'h11);
    chk("dut0 held overrun", 16'(ov[0]), 16'h1);
    ready[0] = 1'b1;
    tick();
    ready[0] = 1'b0;
    @(negedge clk);
    chk("dut0 valid after overrun accept", 16'(vld[0]), 16'h0);
    chk("dut0 overrun after accept", 16'(ov[0]), 16'h0);
    ready[0] = 1'b1;
    send(0, 16'h33, 1'b0, 4'b0, -1, -1, 1'b0);

    // reset mid-frame while a word with overrun is held
    ready[0] = 1'b0;
    send(0, 16'h5A, 1'b0, 4'b0, -1, -1, 1'b0);
    send(0, 16'h66, 1'b0, 4'b0, -1, -1, 1'b0);
    send(0, 16'hC3, 1'b0, 4'b0, -1, 4, 1'b0);
    ready[0] = 1'b1;
    send(0, 16'h81, 1'b0, 4'b0, -1, -1, 1'b0);

    // short slots, 5 data bits, 2 stop bits
    send(2, 16'h1B, 1'b0, 4'b0, -1, -1, 1'b0);
    send(2, 16'h0A, 1'b0, 4'b0010, -1, -1, 1'b0);

    // random frames on every instance
    for (int d = 0; d < 3; d++) begin
      for (int f = 0; f < 12; f++) begin
        logic [15:0] rd;
        logic [3:0]  sl;
        bit          bp;
        ready[d] = ($urandom % 4) != 0;
        rd = 16'($urandom);
        bp = (PAR[d] != 0) ? bit'($urandom % 2) : 1'b0;
        sl = (($urandom % 4) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
        send(d, rd, bp, sl, -1, -1, 1'b0);
      end
      ready[d] = 1'b1;
      repeat (4) tick();
    end

    repeat (10) tick();
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("dut%0d words outstanding", d), 16'(qsize(d)), 16'h0);
      chk($sformatf("dut%0d final valid", d), 16'(vld[d]), 16'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
